// File: rtl/lsu_mem_if.sv
// lsu_mem_if: bundle between the MEM pipeline stage and lsu_mem (address/data request, load result, IO registers)
interface lsu_mem_if;
    logic [31:0] i_addr;
    logic [31:0] i_st_data;
    logic        i_st_en;
    logic [1:0]  i_store_sel;
    logic [2:0]  i_load_sel;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] o_ld_data;
    logic        o_misaligned;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [31:0] o_io_hex_lo;
    logic [31:0] o_io_hex_hi;
    logic [31:0] o_io_lcd;
    modport slave (
        input  i_addr, i_st_data, i_st_en, i_store_sel, i_load_sel, i_io_sw, i_io_btn,
        output o_ld_data, o_misaligned, o_io_ledr, o_io_ledg, o_io_hex_lo, o_io_hex_hi, o_io_lcd
    );
    modport master (
        output i_addr, i_st_data, i_st_en, i_store_sel, i_load_sel, i_io_sw, i_io_btn,
        input  o_ld_data, o_misaligned, o_io_ledr, o_io_ledg, o_io_hex_lo, o_io_hex_hi, o_io_lcd
    );
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: 8 KiB data memory plus memory-mapped IO registers, zero-latency loads and byte-lane stores
module lsu_mem (
    input logic      i_clk,
    input logic      i_rst_n,
    lsu_mem_if.slave bus
);
    logic [31:0] dmem [2048];
    logic [31:0] io_q [5];
    logic [31:0] io_d [5];
    logic [31:0] sw_meta_q, sw_q;
    logic [3:0]  btn_meta_q, btn_q;
    logic [31:0] a;
    logic [2:0]  io_sel;
    logic        is_dmem, is_io, is_sw, is_btn;
    logic        st_half, st_word, ld_half, ld_word, ld_mis, we;
    logic [3:0]  be;
    logic [31:0] wmask, wdata, rword, rsh;
    assign a       = bus.i_addr;
    assign io_sel  = a[14:12];
    assign is_dmem = a[31:13] == '0;
    assign is_io   = a[31:16] == 16'h1000 && !a[15] && io_sel < 3'd5;
    assign is_sw   = a[31:12] == 20'h10010;
    assign is_btn  = a[31:12] == 20'h10011;
    assign st_half = bus.i_store_sel == 2'b01;
    assign st_word = bus.i_store_sel == 2'b10;
    assign ld_half = bus.i_load_sel == 3'b001 || bus.i_load_sel == 3'b101;
    assign ld_word = bus.i_load_sel == 3'b010;
    assign ld_mis  = (ld_half && a[0]) || (ld_word && a[1:0] != 2'b00);
    assign bus.o_misaligned = bus.i_st_en ? (st_half && a[0]) || (st_word && a[1:0] != 2'b00) : ld_mis;
    // Stores are dropped while reset is held so nothing leaks past an aborted cycle
    assign we    = i_rst_n && bus.i_st_en && bus.i_store_sel != 2'b11 && !bus.o_misaligned;
    assign be    = st_word ? 4'b1111 : st_half ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a[1:0];
    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wdata = st_word ? bus.i_st_data : st_half ? {2{bus.i_st_data[15:0]}} : {4{bus.i_st_data[7:0]}};
    assign rword = is_dmem ? dmem[a[12:2]] : is_io ? io_q[io_sel] : is_sw ? sw_q
                 : is_btn ? {28'd0, btn_q} : '0;
    assign rsh   = rword >> {a[1:0], 3'b000};
    assign bus.o_ld_data = ld_mis                        ? '0
                         : bus.i_load_sel == 3'b000 ? {{24{rsh[7]}}, rsh[7:0]}
                         : bus.i_load_sel == 3'b001 ? {{16{rsh[15]}}, rsh[15:0]}
                         : bus.i_load_sel == 3'b010 ? rword
                         : bus.i_load_sel == 3'b100 ? {24'd0, rsh[7:0]}
                         : bus.i_load_sel == 3'b101 ? {16'd0, rsh[15:0]}
                         : '0;
    always_comb begin
        for (int r = 0; r < 5; r++)
            io_d[r] = (we && is_io && io_sel == r[2:0]) ? (io_q[r] & ~wmask) | (wdata & wmask) : io_q[r];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 5; r++) io_q[r] <= '0;
            sw_meta_q  <= '0;
            sw_q       <= '0;
            btn_meta_q <= '0;
            btn_q      <= '0;
        end else begin
            io_q       <= io_d;
            sw_meta_q  <= bus.i_io_sw;
            sw_q       <= sw_meta_q;
            btn_meta_q <= bus.i_io_btn;
            btn_q      <= btn_meta_q;
        end
    end
    // DMEM has no reset so its contents survive a system reset
    always_ff @(posedge i_clk) begin
        if (we && is_dmem)
            for (int b = 0; b < 4; b++)
                if (be[b]) dmem[a[12:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
    assign bus.o_io_ledr   = io_q[0];
    assign bus.o_io_ledg   = io_q[1];
    assign bus.o_io_hex_lo = io_q[2];
    assign bus.o_io_hex_hi = io_q[3];
    assign bus.o_io_lcd    = io_q[4];
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed checks of the memory map plus randomized traffic against a byte-addressed model
module tb_lsu_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   npass = 0;
    int   ntot = 0;
    lsu_mem_if bus ();
    lsu_mem dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0]  m_mem [64];
    logic [31:0] m_io [5];
    logic [31:0] sw_val = '0;
    logic [3:0]  btn_val = '0;
    function automatic int lsz(logic [2:0] ls);
        case (ls)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction
    function automatic int ssz(logic [1:0] ss);
        return ss == 2'b00 ? 1 : ss == 2'b01 ? 2 : ss == 2'b10 ? 4 : 0;
    endfunction
    function automatic logic [7:0] m_byte(logic [31:0] ad);
        int sh = 8 * int'(ad[1:0]);
        if (ad[31:13] == '0) return m_mem[ad[5:0]];
        if (ad[31:16] == 16'h1000 && ad[15:12] < 4'd5) return m_io[ad[14:12]][sh +: 8];
        if (ad[31:12] == 20'h10010) return sw_val[sh +: 8];
        if (ad[31:12] == 20'h10011) return sh == 0 ? {4'd0, btn_val} : 8'd0;
        return 8'd0;
    endfunction
    function automatic logic [31:0] m_load(logic [31:0] ad, logic [2:0] ls);
        int n = lsz(ls);
        logic [31:0] v = '0;
        if (n == 0 || (ad & (n - 1)) != 0) return '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m_byte(ad + i);
        if (!ls[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!ls[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction
    task automatic m_store(logic [31:0] ad, logic [31:0] d, logic [1:0] ss);
        int n = ssz(ss);
        if (n == 0 || (ad & (n - 1)) != 0) return;
        for (int i = 0; i < n; i++) begin
            logic [31:0] b = ad + i;
            if (b[31:13] == '0) m_mem[b[5:0]] = d[8*i +: 8];
            else if (b[31:16] == 16'h1000 && b[15:12] < 4'd5) m_io[b[14:12]][8*int'(b[1:0]) +: 8] = d[8*i +: 8];
        end
    endtask
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask
    task automatic drive(logic [31:0] ad, logic [31:0] d, logic st, logic [1:0] ss, logic [2:0] ls);
        bus.i_addr = ad;
        bus.i_st_data = d;
        bus.i_st_en = st;
        bus.i_store_sel = ss;
        bus.i_load_sel = ls;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic st(logic [31:0] ad, logic [31:0] d, logic [1:0] ss);
        drive(ad, d, 1'b1, ss, 3'b010);
        m_store(ad, d, ss);
        step();
        drive(ad, '0, 1'b0, 2'b11, 3'b010);
    endtask
    task automatic ld(string tag, logic [31:0] ad, logic [2:0] ls, logic [31:0] exp);
        drive(ad, '0, 1'b0, 2'b11, ls);
        #1;
        chk(tag, bus.o_ld_data, exp);
    endtask
    task automatic chk_io(string tag);
        chk({tag, "_ledr"}, bus.o_io_ledr, m_io[0]);
        chk({tag, "_ledg"}, bus.o_io_ledg, m_io[1]);
        chk({tag, "_hexlo"}, bus.o_io_hex_lo, m_io[2]);
        chk({tag, "_hexhi"}, bus.o_io_hex_hi, m_io[3]);
        chk({tag, "_lcd"}, bus.o_io_lcd, m_io[4]);
    endtask
    initial begin
        logic [31:0] ad, d;
        logic        s;
        logic [1:0]  ss;
        logic [2:0]  ls;
        int          n, k;
        for (int r = 0; r < 5; r++) m_io[r] = '0;
        drive('0, '0, 1'b0, 2'b11, 3'b010);
        bus.i_io_sw = '0;
        bus.i_io_btn = '0;
        repeat (2) step();
        chk_io("reset");
        rst_n = 1'b1;
        step();
        for (int w = 0; w < 16; w++) st(w * 4, '0, 2'b10);
        st(32'h10, 32'hDEADBEEF, 2'b10);
        ld("lw_10", 32'h10, 3'b010, 32'hDEADBEEF);
        ld("lb_13", 32'h13, 3'b000, 32'hFFFFFFDE);
        ld("lbu_13", 32'h13, 3'b100, 32'h000000DE);
        ld("lhu_12", 32'h12, 3'b101, 32'h0000DEAD);
        ld("lh_12", 32'h12, 3'b001, 32'hFFFFDEAD);
        st(32'h11, 32'h55, 2'b00);
        ld("sb_11", 32'h10, 3'b010, 32'hDEAD55EF);
        st(32'h12, 32'h1234, 2'b01);
        ld("sh_12", 32'h10, 3'b010, 32'h123455EF);
        drive(32'h6, 32'hCAFEF00D, 1'b1, 2'b10, 3'b010);
        #1;
        chk("sw_mis_flag", {31'd0, bus.o_misaligned}, 32'd1);
        step();
        ld("sw_mis_kept", 32'h4, 3'b010, 32'h0);
        ld("lh_mis_data", 32'h1, 3'b001, 32'h0);
        chk("lh_mis_flag", {31'd0, bus.o_misaligned}, 32'd1);
        st(32'h1000_0000, 32'hFF, 2'b10);
        chk("ledr_st", bus.o_io_ledr, 32'hFF);
        st(32'h1000_2001, 32'h7F, 2'b00);
        chk("hexlo_sb", bus.o_io_hex_lo, 32'h7F00);
        ld("ledr_rd", 32'h1000_0000, 3'b010, 32'hFF);
        st(32'h1001_0000, 32'h1111, 2'b10);
        bus.i_io_sw = 32'hA5A5A5A5;
        bus.i_io_btn = 4'hA;
        ld("sw_edge0", 32'h1001_0000, 3'b010, 32'h0);
        step();
        ld("sw_edge1", 32'h1001_0000, 3'b010, 32'h0);
        step();
        sw_val = 32'hA5A5A5A5;
        btn_val = 4'hA;
        ld("sw_edge2", 32'h1001_0000, 3'b010, 32'hA5A5A5A5);
        ld("btn_rd", 32'h1001_1000, 3'b010, 32'hA);
        ld("unmapped", 32'h2000_0000, 3'b010, 32'h0);
        chk("unmapped_mis", {31'd0, bus.o_misaligned}, 32'd0);
        drive(32'h1000_1000, 32'h1234, 1'b1, 2'b10, 3'b010);
        #1;
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 5; r++) m_io[r] = '0;
        chk_io("async_rst");
        step();
        chk("rst_ledg_edge", bus.o_io_ledg, 32'h0);
        drive('0, '0, 1'b0, 2'b11, 3'b010);
        rst_n = 1'b1;
        step();
        chk("rst_ledg_after", bus.o_io_ledg, 32'h0);
        ld("dmem_kept", 32'h10, 3'b010, 32'h123455EF);
        repeat (2) step();
        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 9);
            if (k < 5) ad = $urandom_range(0, 63);
            else if (k < 8) ad = 32'h1000_0000 | ($urandom_range(0, 4) << 12) | $urandom_range(0, 4095);
            else begin
                case ($urandom_range(0, 3))
                    0:       ad = 32'h1001_0000;
                    1:       ad = 32'h1001_1000;
                    2:       ad = 32'h2000_0000;
                    default: ad = 32'h1000_5000;
                endcase
                ad = ad + $urandom_range(0, 4095);
            end
            s = 1'($urandom_range(0, 1));
            ss = 2'($urandom_range(0, 3));
            ls = 3'($urandom_range(0, 7));
            d = $urandom;
            drive(ad, d, s, ss, ls);
            #1;
            n = s ? ssz(ss) : lsz(ls);
            chk("rnd_mis", {31'd0, bus.o_misaligned}, {31'd0, n > 1 && (ad & (n - 1)) != 0});
            if (!s) chk("rnd_ld", bus.o_ld_data, m_load(ad, ls));
            else m_store(ad, d, ss);
            step();
            chk_io("rnd");
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
